pulse_swallow_ctrl: RTL

PULSE_SWALLOW_CTRL -- requirements
Module: pulse_swallow_ctrl

---
 rtl/pulse_swallow_ctrl_pkg.sv | 18 +
 rtl/pulse_swallow_ctrl_if.sv | 38 +++
 rtl/pulse_swallow_ctrl_counter.sv | 49 ++++
 rtl/pulse_swallow_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/pulse_swallow_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// psc_pkg -- shared definitions for the pulse-swallow divider controller.
//
// Contents:
//   CNT_W_DEFAULT : default width of the P (program) and S (swallow) counts
//   psc_state_t   : controller state (IDLE = no configuration held,
//                   RUN = counting prescaler cycles)
// ---------------------------------------------------------------------------
package psc_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01
    } psc_state_t;

endpackage : psc_pkg

// File: rtl/pulse_swallow_ctrl_if.sv
// ---------------------------------------------------------------------------
// pulse_swallow_ctrl_if -- configuration handshake bus for pulse_swallow_ctrl.
//
// Signals:
//   p_val     : program count P (prescaler cycles per output period)
//   s_val     : swallow count S (cycles per period at modulus M+1)
//   cfg_valid : P/S pair offered by the master
//   cfg_ready : controller accepts the pair this cycle
// Modports:
//   master : the configuring agent (drives P/S/valid)
//   slave  : the controller (drives ready)
// ---------------------------------------------------------------------------
interface pulse_swallow_ctrl_if
    import psc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
);

    logic [CNT_W-1:0] p_val;
    logic [CNT_W-1:0] s_val;
    logic             cfg_valid;
    logic             cfg_ready;

    modport master (
        output p_val,
        output s_val,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  p_val,
        input  s_val,
        input  cfg_valid,
        output cfg_ready
    );

endinterface : pulse_swallow_ctrl_if

// File: rtl/pulse_swallow_ctrl_counter.sv
// ---------------------------------------------------------------------------
// mod_counter -- loadable wrap-at-limit counter.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset (count -> 0)
//   en         : advance the count this cycle
//   load       : load load_val this cycle (wins over en)
//   load_val   : value loaded on load
//   last       : terminal value; the count wraps from last to 0
//   count_next : value the count takes at the next edge (lets the parent
//                register its outputs from next-state without extra latency)
//   tc         : terminal count, high while the count equals last
// ---------------------------------------------------------------------------
module mod_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] last,
    output logic [W-1:0] count_next,
    output logic         tc
);

    logic [W-1:0] count_reg;

    assign tc = (count_reg == last);

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (en) begin
            count_next = tc ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule : mod_counter

// File: rtl/pulse_swallow_ctrl.sv
// ---------------------------------------------------------------------------
// pulse_swallow_ctrl -- dual-modulus prescaler control for a pulse-swallow
// divider. Each output period lasts P prescaler cycles; during the first S
// of them mc requests divide-by-(M+1), afterwards divide-by-M. div_out
// pulses on the last cycle of every period.
//
// Ports:
//   clk     : prescaler output clock, rising edge
//   rst     : asynchronous active-low reset
//   cfg     : configuration handshake (slave side of pulse_swallow_ctrl_if)
//   mc      : modulus control, 1 = divide by M+1, 0 = divide by M
//   div_out : one-cycle pulse at the end of each output period
//   cfg_err : sticky, set when an illegal P/S pair (P < 2 or S >= P) is
//             transferred; cleared only by reset
//
// Build option:
//   PSC_RETIME_EN : adds one register stage on mc and div_out (one cycle of
//                   extra latency, reset value 0). cfg_ready is unaffected.
// ---------------------------------------------------------------------------
module pulse_swallow_ctrl
    import psc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    pulse_swallow_ctrl_if.slave   cfg,
    output logic                  mc,
    output logic                  div_out,
    output logic                  cfg_err
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    psc_state_t       state_reg, state_next;
    logic [CNT_W-1:0] p_reg, p_next;
    logic [CNT_W-1:0] s_reg, s_next;
    logic             err_reg, err_next;
    logic             mc_reg, mc_next;
    logic             div_reg, div_next;

    logic [CNT_W-1:0] cnt_next;
    logic             cnt_tc;
    logic             cfg_ready_int;
    logic             xfer;
    logic             legal;
    logic             load;

    // Ready in IDLE, or on the last cycle of a running period so a new pair
    // always starts on a period boundary. In IDLE p_reg is 0, so the counter
    // limit is all-ones and tc cannot fire spuriously.
    assign cfg_ready_int = (state_reg == IDLE) || ((state_reg == RUN) && cnt_tc);
    assign cfg.cfg_ready = cfg_ready_int;

    assign xfer  = cfg.cfg_valid && cfg_ready_int;
    assign legal = (cfg.p_val >= TWO) && (cfg.s_val < cfg.p_val);
    assign load  = xfer && legal;

    mod_counter #(
        .W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .en         (state_reg == RUN),
        .load       (load),
        .load_val   ('0),
        .last       (p_reg - ONE),
        .count_next (cnt_next),
        .tc         (cnt_tc)
    );

    always_comb begin
        state_next = state_reg;
        p_next     = p_reg;
        s_next     = s_reg;
        err_next   = err_reg || (xfer && !legal);
        if (load) begin
            state_next = RUN;
            p_next     = cfg.p_val;
            s_next     = cfg.s_val;
        end
        // Outputs are produced from the next count/config so they line up
        // with the counter value of the cycle they describe.
        mc_next  = (state_next == RUN) && (cnt_next < s_next);
        div_next = (state_next == RUN) && (cnt_next == p_next - ONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            p_reg     <= '0;
            s_reg     <= '0;
            err_reg   <= 1'b0;
            mc_reg    <= 1'b0;
            div_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            p_reg     <= p_next;
            s_reg     <= s_next;
            err_reg   <= err_next;
            mc_reg    <= mc_next;
            div_reg   <= div_next;
        end
    end

    assign cfg_err = err_reg;

`ifdef PSC_RETIME_EN
    logic mc_dly_reg;
    logic div_dly_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mc_dly_reg  <= 1'b0;
            div_dly_reg <= 1'b0;
        end else begin
            mc_dly_reg  <= mc_reg;
            div_dly_reg <= div_reg;
        end
    end

    assign mc      = mc_dly_reg;
    assign div_out = div_dly_reg;
`else
    assign mc      = mc_reg;
    assign div_out = div_reg;
`endif

endmodule : pulse_swallow_ctrl
